// File: rtl/rs_issue_sel.sv
// Oldest-first issue select for one reservation station: an age matrix is updated at allocation,
// a combinational one-hot grant is returned in rs1, and the winning packet is registered into ex0.
package rs_issue_sel_pkg;
  typedef struct packed {
    logic       valid;
    logic [5:0] rob_id;
  } t_nuke_pkt;

  typedef struct packed {
    logic [7:0]  rob_id;
    logic [7:0]  uop;
    logic [15:0] imm;
  } t_iss_pkt;
endpackage

module rs_issue_sel
  import rs_issue_sel_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  t_nuke_pkt              nuke_rb1,
  input  logic [NUM_ENTRIES-1:0] alloc_rs0,
  input  logic [NUM_ENTRIES-1:0] req_issue_rs1,
  input  t_iss_pkt               issue_pkt_rs1 [NUM_ENTRIES],
  output logic [NUM_ENTRIES-1:0] gnt_issue_rs1,
  input  logic                   ex_stall_ex0,
  output logic                   iss_valid_ex0,
  output t_iss_pkt               iss_pkt_ex0
);
  localparam int IW = $clog2(NUM_ENTRIES);

  // age_q[i][j] = 1 means entry i is older than entry j; the diagonal is never written.
  logic [NUM_ENTRIES-1:0] age_q   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_col [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] cand;
  logic [NUM_ENTRIES-1:0] win_oh;
  logic [IW-1:0]          win_idx;
  logic                   gnt_en;
  logic                   unused_nuke_bits;

  assign unused_nuke_bits = ^nuke_rb1.rob_id;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (i != j) begin
            if (alloc_rs0[j])      age_q[i][j] <= 1'b1;
            else if (alloc_rs0[i]) age_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_col[i] = '0;
      for (int j = 0; j < NUM_ENTRIES; j++) age_col[i][j] = age_q[j][i];
    end
  end

  // A requester is a candidate when no older entry is also requesting.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      cand[i] = req_issue_rs1[i] & ~|(req_issue_rs1 & age_col[i]);
  end

  // Ties only arise between never-allocated entries; the lowest index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (cand[i]) win_idx = IW'(i);
    win_oh = cand & (~cand + NUM_ENTRIES'(1));
  end

  assign gnt_en        = reset_n & ~nuke_rb1.valid & ~(iss_valid_ex0 & ex_stall_ex0);
  assign gnt_issue_rs1 = gnt_en ? win_oh : '0;

  // ex0 handshake: the packet transfers to EX on a cycle with iss_valid_ex0=1 and
  // ex_stall_ex0=0; while stalled, valid and packet hold and no new grant is given.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iss_valid_ex0 <= 1'b0;
      iss_pkt_ex0   <= '0;
    end else if (nuke_rb1.valid) begin
      iss_valid_ex0 <= 1'b0;
    end else if (iss_valid_ex0 && ex_stall_ex0) begin
      iss_valid_ex0 <= 1'b1;
    end else if (|gnt_issue_rs1) begin
      iss_valid_ex0 <= 1'b1;
      iss_pkt_ex0   <= issue_pkt_rs1[win_idx];
    end else begin
      iss_valid_ex0 <= 1'b0;
    end
  end

  a_alloc_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(alloc_rs0));
  a_gnt_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_issue_rs1));
  a_gnt_has_req:  assert property (@(posedge clk) disable iff (!reset_n)
                                   (gnt_issue_rs1 & ~req_issue_rs1) == '0);
  a_no_alloc_gnt: assert property (@(posedge clk) disable iff (!reset_n)
                                   (alloc_rs0 & gnt_issue_rs1) == '0);
endmodule
